// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
//   - stage state encoding (EMPTY / ONE / FULL), 2 bits
//   - default NOP instruction word
//   - occupancy encoding (entries held), identical to the state encoding
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipeStateE;

  // Flat constants for the state register.
  localparam logic [1:0] ST_EMPTY = PS_EMPTY;
  localparam logic [1:0] ST_ONE   = PS_ONE;
  localparam logic [1:0] ST_FULL  = PS_FULL;

  localparam logic [15:0] NOP_IR_DEF = 16'hF000;

  // Occupancy reported downstream is the state value itself; 3 is unused.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_slot.sv
// One IR + payload register entry.
// Ports:
//   clk, reset (sync, active low)  - clock and reset
//   load                           - capture irIn / payloadIn
//   clear                          - load NOP_IR / zero payload (wins over load)
//   irIn, payloadIn                - entry input
//   ir, payload                    - entry contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          IR_W   = 16,
  parameter int          DATA_W = 64,
  parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [IR_W-1:0]   irIn,
  input  logic [DATA_W-1:0] payloadIn,
  output logic [IR_W-1:0]   ir,
  output logic [DATA_W-1:0] payload
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      ir      <= NOP_IR;
      payload <= '0;
    end else if (load) begin
      ir      <= irIn;
      payload <= payloadIn;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register between two stages: one IR plus opaque payload,
// valid/ready handshake, 2-entry skid buffer (main + skid) so in_ready comes
// from registered state, flush-to-NOP, and optional IR field override on
// capture.
// Ports:
//   clk, reset (sync, active low)
//   in_valid/in_ready/in_ir/in_payload  - upstream beat
//   in_mod_en/in_mod_field              - replace IR[MOD_LSB+:MOD_W] on capture
//   flush                               - drop everything held and offered
//   out_valid/out_ready/out_ir/out_payload - downstream beat (NOP/0 when idle)
//   occupancy                           - entries held (0..2)
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              IR_W    = 16,
  parameter int              DATA_W  = 64,
  parameter logic [IR_W-1:0] NOP_IR  = IR_W'(NOP_IR_DEF),
  parameter int              MOD_LSB = 9,
  parameter int              MOD_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [DATA_W-1:0] in_payload,
  input  logic              in_mod_en,
  input  logic [MOD_W-1:0]  in_mod_field,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IR_W-1:0]   out_ir,
  output logic [DATA_W-1:0] out_payload,
  output logic [1:0]        occupancy
);

  logic [1:0]        state, nextState;
  logic              inFire, outFire;
  logic [IR_W-1:0]   capIr;
  logic              mainLoad, mainClr, skidLoad, skidClr;
  logic [IR_W-1:0]   mainIrIn, skidIr;
  logic [DATA_W-1:0] mainPayloadIn, skidPayload;

  // Flush gates in_ready so an upstream beat is never consumed on that cycle.
  assign in_ready  = (state != ST_FULL) && !flush;
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;

  always_comb begin
    capIr = in_ir;
    if (in_mod_en) capIr[MOD_LSB +: MOD_W] = in_mod_field;
  end

  // Main entry refills from skid when draining FULL, otherwise from upstream.
  assign mainIrIn      = (state == ST_FULL) ? skidIr      : capIr;
  assign mainPayloadIn = (state == ST_FULL) ? skidPayload : in_payload;

  always_comb begin
    nextState = state;
    mainLoad  = 1'b0;
    mainClr   = 1'b0;
    skidLoad  = 1'b0;
    skidClr   = 1'b0;
    case (state)
      ST_EMPTY: if (inFire) begin
        nextState = ST_ONE;
        mainLoad  = 1'b1;
      end
      ST_ONE: begin
        if (inFire && outFire) begin
          mainLoad = 1'b1;
        end else if (inFire) begin
          nextState = ST_FULL;
          skidLoad  = 1'b1;
        end else if (outFire) begin
          nextState = ST_EMPTY;
          mainClr   = 1'b1;
        end
      end
      ST_FULL: if (outFire) begin
        nextState = ST_ONE;
        mainLoad  = 1'b1;
        skidClr   = 1'b1;
      end
      default: begin
        nextState = ST_EMPTY;
        mainClr   = 1'b1;
        skidClr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) state <= ST_EMPTY;
    else                 state <= nextState;
  end

  pipe_slot #(.IR_W(IR_W), .DATA_W(DATA_W), .NOP_IR(NOP_IR)) uMain (
    .clk      (clk),
    .reset    (reset),
    .load     (mainLoad),
    .clear    (mainClr || flush),
    .irIn     (mainIrIn),
    .payloadIn(mainPayloadIn),
    .ir       (out_ir),
    .payload  (out_payload)
  );

  pipe_slot #(.IR_W(IR_W), .DATA_W(DATA_W), .NOP_IR(NOP_IR)) uSkid (
    .clk      (clk),
    .reset    (reset),
    .load     (skidLoad),
    .clear    (skidClr || flush),
    .irIn     (capIr),
    .payloadIn(in_payload),
    .ir       (skidIr),
    .payload  (skidPayload)
  );

endmodule
